regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Round-robin arbiter that shares the 32×64 register file's single write port among `NREQ` requesters, e.g. the ALU writeback, load return and link-register update paths. It accepts one write per cycle through a valid/ready handshake and drives the register file's `RegWrite`/`WriteRegister`/`WriteData` inputs from a registered output stage. It supports a lock so one requester can issue back-to-back atomic writes, for example a load-pair writeback. The read side (the 32:1 read-mux tree) is untouched; this block only sequences writes.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 5: register index width.
- `DATA_W`, 64: write data width.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  requester i has a pending write.
- `req_lock`  in  NREQ  requester i asks to keep the grant after this transfer.
- `req_addr`  in  NREQ*ADDR_W  destination register, requester i at `[i*ADDR_W +: ADDR_W]`.
- `req_data`  in  NREQ*DATA_W  write data, requester i at `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  NREQ  one-hot or zero; transfer for i occurs when `req_valid[i] && req_ready[i]`.
- `RegWrite`  out  1  register file write enable.
- `WriteRegister`  out  ADDR_W  register file write index.
- `WriteData`  out  DATA_W  register file write data.
- `grant_id`  out  $clog2(NREQ)  index of the requester whose write is on the port this cycle.
- `locked`  out  1  arbiter is in the LOCKED state.

## Operation
- **State:** round-robin pointer `ptr` (next-highest-priority index), FSM {IDLE, LOCKED}, lock owner `own`.
- **IDLE arbitration:**
  - The winner is the first i with `req_valid[i]`, scanning `ptr, ptr+1, …` modulo NREQ.
  - `req_ready` is combinational: at most one bit set, and only for the winner.
  - No valid requests means `req_ready` = 0 and the state is unchanged.
- **On each transfer from winner w:**
  - The output stage loads `RegWrite`=1, `WriteRegister`=`req_addr[w]`, `WriteData`=`req_data[w]`, `grant_id`=w.
  - `ptr` becomes (w+1) mod NREQ.
- **Lock:**
  - A transfer with `req_lock[w]`=1 moves the FSM to LOCKED with `own`=w.
  - In LOCKED, only `own` may be granted. Its `req_ready` follows its `req_valid`; all other ready bits are 0.
  - LOCKED exits to IDLE on a transfer with `req_lock[own]`=0, or on any cycle where `req_valid[own]`=0. Release takes effect the next cycle.
  - `ptr` stays at (own+1) mod NREQ throughout.
- **No transfer this cycle:** the output stage loads `RegWrite`=0. `WriteRegister`, `WriteData` and `grant_id` hold their previous values.
- **Requester obligation:** hold valid, addr, data and lock stable until the transfer. The arbiter does not check this.

## Timing
- **Latency:** the handshake completes in cycle N; the write is presented to the register file in cycle N+1 and committed at the end of N+1.
- **Throughput:** one write per cycle, sustained.
- **Fairness:** with all requesters continuously valid and unlocked, grants rotate 0,1,…,NREQ-1,0,…
- **Reset** (synchronous, wins over all other events):
  - Next-cycle outputs: `RegWrite`=0, `WriteRegister`=0, `WriteData`=0, `grant_id`=0, `locked`=0.
  - Internal state: `ptr`=0, FSM=IDLE.
  - `req_ready`=0 while `reset` is high.
- **Reset mid-operation:** a transfer handshaked in the same cycle as reset is discarded, so `RegWrite`=0 the following cycle. A held lock is dropped.
- **Simultaneous events:**
  - A lock release and a new request from another requester in the same cycle are not both honoured. The other requester is granted no earlier than the cycle after release.
- **Write/read ordering:** the register file's read-after-write ordering for same-cycle reads is unchanged; this block adds one cycle before a write is visible.

## Configuration
- **`REGARB_XZR_DROP_EN`**
  - Defined: a transfer with `req_addr`=31 (XZR) is handshaked normally and advances `ptr` and the lock logic, but the output stage loads `RegWrite`=0.
  - Undefined: writes to index 31 pass through to the register file like any other index.

## Test plan
- **Reset:** assert `reset` for 2 cycles with all `req_valid`=1 -> `req_ready`=0, and one cycle after deassertion `RegWrite`=0, `WriteRegister`=0, `WriteData`=0, `grant_id`=0.
- **Round-robin:** all four requesters valid for 8 cycles, requester i writing addr i+1 with data 0x1111_0000_0000_000i -> grants 0,1,2,3,0,1,2,3. Each write appears on `RegWrite`/`WriteRegister`/`WriteData` exactly one cycle after its handshake.
- **Lock:**
  - Requester 2 sends 3 writes with `req_lock`=1,1,0 while 0, 1 and 3 stay valid -> `locked`=1 for those cycles and only `req_ready[2]` is set.
  - The next grant goes to requester 3.
- **Lock released by valid drop:** requester 1 locks, then drops `req_valid` -> `locked`=0 the next cycle, and requester 2 is granted.
- **Reset mid-lock:** requester 1 locked with a handshake in the same cycle as `reset` -> next cycle `RegWrite`=0 and `locked`=0, and after release requester 0 is granted first.
- **XZR write:** requester 0 writes addr 31, data 0xDEAD_BEEF -> with `REGARB_XZR_DROP_EN` defined, `req_ready[0]`=1 and `RegWrite`=0 next cycle; without it, `RegWrite`=1 and `WriteRegister`=31.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin, lockable arbiter for the 32x64 register file's single write port.
// Build option REGARB_XZR_DROP_EN: handshake writes to index 31 (XZR) but suppress RegWrite.
module regfile_write_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_lock,
    input  logic [NREQ*ADDR_W-1:0]  req_addr,
    input  logic [NREQ*DATA_W-1:0]  req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    RegWrite,
    output logic [ADDR_W-1:0]       WriteRegister,
    output logic [DATA_W-1:0]       WriteData,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    locked
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    w_ptr_nxt;
    logic [IDW-1:0]    r_own;
    logic [IDW-1:0]    w_own_nxt;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [IDW-1:0]    r_gid;

    logic [IDW-1:0]    w_win;
    logic              w_win_vld;
    logic              w_is_locked;
    logic [IDW-1:0]    w_gnt_id;
    logic              w_gnt_vld;
    logic              w_gnt_lock;
    logic              w_xfer;
    logic              w_we;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_data;
    logic [IDW-1:0]    w_ptr_inc;

    // Index base+offset wrapped into 0..NREQ-1 (offset is always < NREQ).
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        return (sum >= NREQ) ? IDW'(sum - NREQ) : IDW'(sum);
    endfunction

    // Round-robin scan: first valid requester starting at the pointer.
    always_comb begin
        w_win     = '0;
        w_win_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_win     = (!w_win_vld && req_valid[rr_index(r_ptr, k)]) ? rr_index(r_ptr, k) : w_win;
            w_win_vld = w_win_vld | req_valid[rr_index(r_ptr, k)];
        end
    end

    // While locked only the owner competes; reset masks every grant.
    assign w_is_locked = (r_state == ST_LOCKED);
    assign w_gnt_id    = w_is_locked ? r_own : w_win;
    assign w_gnt_vld   = w_is_locked ? req_valid[r_own] : w_win_vld;
    assign w_xfer      = w_gnt_vld & ~reset;
    assign req_ready   = w_xfer ? (NREQ'(1) << w_gnt_id) : '0;
    assign w_gnt_lock  = req_lock[w_gnt_id];
    assign w_gnt_addr  = req_addr[int'(w_gnt_id)*ADDR_W +: ADDR_W];
    assign w_gnt_data  = req_data[int'(w_gnt_id)*DATA_W +: DATA_W];
    assign w_ptr_inc   = rr_index(w_gnt_id, 1);

`ifdef REGARB_XZR_DROP_EN
    assign w_we = w_xfer && (w_gnt_addr != ADDR_W'(31));
`else
    assign w_we = w_xfer;
`endif

    // Next-state logic for the IDLE/LOCKED FSM, pointer and lock owner.
    always_comb begin
        w_state_nxt = r_state;
        w_own_nxt   = r_own;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_ptr_nxt = w_ptr_inc;
                    if (w_gnt_lock) begin
                        w_state_nxt = ST_LOCKED;
                        w_own_nxt   = w_gnt_id;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                // Pointer already sits at own+1; a missing request also releases.
                if (w_xfer && w_gnt_lock) begin
                    w_state_nxt = ST_LOCKED;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers and the registered register-file output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_own   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_gid   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_own   <= w_own_nxt;
            r_we    <= w_we;
            if (w_xfer) begin
                r_waddr <= w_gnt_addr;
                r_wdata <= w_gnt_data;
                r_gid   <= w_gnt_id;
            end else begin
                r_waddr <= r_waddr;
                r_wdata <= r_wdata;
                r_gid   <= r_gid;
            end
        end
    end

    assign RegWrite      = r_we;
    assign WriteRegister = r_waddr;
    assign WriteData     = r_wdata;
    assign grant_id      = r_gid;
    assign locked        = w_is_locked;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed test-plan scenarios plus
// randomized traffic, all checked against a behavioural model of the arbitration rules.
module tb_regfile_write_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_lock;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   RegWrite;
    logic [ADDR_W-1:0]      WriteRegister;
    logic [DATA_W-1:0]      WriteData;
    logic [1:0]             grant_id;
    logic                   locked;

    logic [ADDR_W-1:0] t_addr [NREQ];
    logic [DATA_W-1:0] t_data [NREQ];

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int              m_ptr;
    int              m_own;
    bit              m_locked;
    bit              m_known;
    logic [63:0]     e_we, e_addr, e_data, e_gid, e_locked;
    logic [NREQ-1:0] m_xfer;
    bit              pend [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = t_addr[i];
            req_data[i*DATA_W +: DATA_W] = t_data[i];
        end
    end

    regfile_write_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .grant_id(grant_id), .locked(locked)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Settle after input changes, compare DUT to model, then advance the model over the coming edge.
    task automatic settle_and_model();
        int w;
        logic [NREQ-1:0] exp_rdy;
        #1;
        w = -1;
        if (!reset) begin
            if (m_locked) begin
                if (req_valid[m_own]) w = m_own;
            end else begin
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
        end
        exp_rdy = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        check_val("model_ready", 64'(req_ready), 64'(exp_rdy));
        if (m_known) begin
            check_val("model_regwrite", 64'(RegWrite), e_we);
            check_val("model_waddr", 64'(WriteRegister), e_addr);
            check_val("model_wdata", WriteData, e_data);
            check_val("model_grant_id", 64'(grant_id), e_gid);
            check_val("model_locked", 64'(locked), e_locked);
        end
        m_xfer = exp_rdy & req_valid;
        if (reset) begin
            m_ptr = 0; m_locked = 1'b0; m_own = 0;
            e_we = 64'd0; e_addr = 64'd0; e_data = 64'd0; e_gid = 64'd0;
            m_known = 1'b1;
        end else if (w >= 0) begin
            e_we = 64'd1;
`ifdef REGARB_XZR_DROP_EN
            if (t_addr[w] == 5'd31) e_we = 64'd0;
`endif
            e_addr = 64'(t_addr[w]);
            e_data = t_data[w];
            e_gid  = 64'(w);
            m_ptr  = (w + 1) % NREQ;
            if (m_locked) begin
                m_locked = req_lock[w];
            end else if (req_lock[w]) begin
                m_locked = 1'b1;
                m_own    = w;
            end
        end else begin
            e_we     = 64'd0;
            m_locked = 1'b0;
        end
        e_locked = 64'(m_locked);
    endtask

    task automatic next_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_lock  = 4'b0000;
        for (int i = 0; i < NREQ; i++) begin
            t_addr[i] = ADDR_W'(i + 1);
            t_data[i] = 64'h1111_0000_0000_0000 | 64'(i);
            pend[i]   = 1'b0;
        end
        m_known = 1'b0; m_locked = 1'b0; m_ptr = 0; m_own = 0;
        e_we = 64'd0; e_addr = 64'd0; e_data = 64'd0; e_gid = 64'd0; e_locked = 64'd0;

        // Reset for two cycles with everyone requesting
        repeat (2) begin
            settle_and_model();
            check_val("rst_ready", 64'(req_ready), 64'd0);
            next_edge();
        end
        reset = 1'b0;

        // Round-robin with all four requesters valid
        for (int c = 0; c < 8; c++) begin
            settle_and_model();
            if (c == 0) begin
                check_val("rst_regwrite", 64'(RegWrite), 64'd0);
                check_val("rst_waddr", 64'(WriteRegister), 64'd0);
                check_val("rst_wdata", WriteData, 64'd0);
                check_val("rst_grant_id", 64'(grant_id), 64'd0);
                check_val("rst_locked", 64'(locked), 64'd0);
            end else begin
                check_val("rr_grant_id", 64'(grant_id), 64'((c - 1) % 4));
                check_val("rr_waddr", 64'(WriteRegister), 64'((c - 1) % 4 + 1));
                check_val("rr_wdata", WriteData, 64'h1111_0000_0000_0000 | 64'((c - 1) % 4));
            end
            check_val("rr_ready", 64'(req_ready), 64'(4'b0001 << (c % 4)));
            next_edge();
        end
        repeat (2) begin
            settle_and_model();
            next_edge();
        end

        // Requester 2 locks for three writes while the others stay valid
        req_lock[2] = 1'b1;
        t_data[2]   = 64'h2222_0000_0000_0001;
        settle_and_model();
        check_val("lock_ready_a", 64'(req_ready), 64'b0100);
        next_edge();
        t_data[2] = 64'h2222_0000_0000_0002;
        settle_and_model();
        check_val("lock_ready_b", 64'(req_ready), 64'b0100);
        check_val("lock_locked_b", 64'(locked), 64'd1);
        next_edge();
        req_lock[2] = 1'b0;
        t_data[2]   = 64'h2222_0000_0000_0003;
        settle_and_model();
        check_val("lock_ready_c", 64'(req_ready), 64'b0100);
        check_val("lock_locked_c", 64'(locked), 64'd1);
        next_edge();
        settle_and_model();
        check_val("lock_locked_d", 64'(locked), 64'd0);
        check_val("lock_next_ready", 64'(req_ready), 64'b1000);
        next_edge();

        // Requester 1 locks then drops valid
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        settle_and_model();
        check_val("drop_ready_e", 64'(req_ready), 64'b0010);
        next_edge();
        req_valid = 4'b0100;
        req_lock  = 4'b0000;
        settle_and_model();
        check_val("drop_locked_f", 64'(locked), 64'd1);
        check_val("drop_ready_f", 64'(req_ready), 64'b0000);
        next_edge();
        settle_and_model();
        check_val("drop_locked_g", 64'(locked), 64'd0);
        check_val("drop_ready_g", 64'(req_ready), 64'b0100);
        next_edge();

        // Reset while requester 1 holds the lock
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        settle_and_model();
        check_val("rml_ready_h", 64'(req_ready), 64'b0010);
        next_edge();
        reset = 1'b1;
        settle_and_model();
        check_val("rml_locked_i", 64'(locked), 64'd1);
        check_val("rml_ready_i", 64'(req_ready), 64'd0);
        next_edge();
        reset     = 1'b0;
        req_valid = 4'b0111;
        req_lock  = 4'b0000;
        settle_and_model();
        check_val("rml_regwrite", 64'(RegWrite), 64'd0);
        check_val("rml_locked", 64'(locked), 64'd0);
        check_val("rml_ready", 64'(req_ready), 64'b0001);
        next_edge();

        // Write to XZR
        req_valid = 4'b0001;
        t_addr[0] = 5'd31;
        t_data[0] = 64'h0000_0000_DEAD_BEEF;
        settle_and_model();
        check_val("xzr_ready", 64'(req_ready), 64'b0001);
        next_edge();
        req_valid = 4'b0000;
        settle_and_model();
`ifdef REGARB_XZR_DROP_EN
        check_val("xzr_regwrite", 64'(RegWrite), 64'd0);
`else
        check_val("xzr_regwrite", 64'(RegWrite), 64'd1);
        check_val("xzr_waddr", 64'(WriteRegister), 64'd31);
        check_val("xzr_wdata", WriteData, 64'h0000_0000_DEAD_BEEF);
`endif
        next_edge();

        // Randomized traffic; requesters hold their request until it transfers
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        pend[i]      = 1'b1;
                        req_valid[i] = 1'b1;
                        t_addr[i]    = ADDR_W'($urandom_range(0, 31));
                        t_data[i]    = {$urandom, $urandom};
                        req_lock[i]  = ($urandom_range(0, 2) == 0);
                    end else begin
                        req_valid[i] = 1'b0;
                        req_lock[i]  = 1'b0;
                    end
                end
            end
            reset = ($urandom_range(0, 49) == 0);
            settle_and_model();
            for (int i = 0; i < NREQ; i++)
                if (m_xfer[i]) pend[i] = 1'b0;
            next_edge();
        end
        reset     = 1'b0;
        req_valid = 4'b0000;
        settle_and_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
